// File: rtl/round_seq_ctrl_pkg.sv
// round_seq_pkg: shared state encoding, stage indices and default skip masks
// Imported by round_seq_ctrl_if, round_seq_ctrl and the testbench.
package round_seq_pkg;
  localparam int STG_W = 5;
  localparam logic [2:0] ENC_IDLE = 3'd0;
  localparam logic [2:0] ENC_INIT = 3'd1;
  localparam logic [2:0] ENC_SEL = 3'd2;
  localparam logic [2:0] ENC_WAIT = 3'd3;
  localparam logic [2:0] ENC_DONE = 3'd4;
  localparam logic [2:0] ENC_ERR = 3'd5;
  typedef enum logic [2:0] {
    S_IDLE = ENC_IDLE,
    S_INIT = ENC_INIT,
    S_SEL = ENC_SEL,
    S_WAIT = ENC_WAIT,
    S_DONE = ENC_DONE,
    S_ERR = ENC_ERR
  } state_t;
  localparam int STG_TREE = 0;
  localparam int STG_COM = 1;
  localparam int STG_CH = 2;
  localparam int STG_SSL = 3;
  localparam int STG_DETA = 4;
  localparam int STG_CN = 5;
  localparam int STG_CV = 6;
  localparam int STG_AUX = 7;
  // Opened rounds skip the aux stage; hidden rounds skip set_seed_lambda and set_deta.
  localparam logic [7:0] SKIP_LC_DEF = 8'(1 << STG_AUX);
  localparam logic [7:0] SKIP_NLC_DEF = 8'((1 << STG_SSL) | (1 << STG_DETA));
  function automatic logic [7:0] default_skip(input logic lc);
    return lc ? SKIP_LC_DEF : SKIP_NLC_DEF;
  endfunction
endpackage

// File: rtl/round_seq_ctrl_if.sv
// round_seq_ctrl_if: run control, status and per-stage start/end handshake bundle
// master: sequencer side (drives stage_start and status, samples requests and stage_end)
// slave:  host/sub-block side (drives start, abort, num_rounds, lc_mode, skip masks, stage_end)
interface round_seq_ctrl_if
  import round_seq_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int ROUND_W = 8
);
  logic start;
  logic abort;
  logic [ROUND_W-1:0] num_rounds;
  logic lc_mode;
  logic [NUM_STAGES-1:0] skip_lc;
  logic [NUM_STAGES-1:0] skip_nlc;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_end;
  logic [ROUND_W-1:0] round_idx;
  logic [STG_W-1:0] cur_stage;
  logic busy;
  logic done;
  logic error;
  logic [STG_W-1:0] err_stage;
  modport master (
    input start, abort, num_rounds, lc_mode, skip_lc, skip_nlc, stage_end,
    output stage_start, round_idx, cur_stage, busy, done, error, err_stage
  );
  modport slave (
    output start, abort, num_rounds, lc_mode, skip_lc, skip_nlc, stage_end,
    input stage_start, round_idx, cur_stage, busy, done, error, err_stage
  );
endinterface

// File: rtl/round_seq_ctrl_watchdog.sv
// seq_watchdog: per-stage timeout counter; fire when count reaches TIMEOUT-1 (TIMEOUT=0 disables)
// clk, reset (async active-low), load clears the count, inc advances it, fire is combinational.
module seq_watchdog #(
  parameter int TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = 16'd4096
) (
  input logic clk,
  input logic reset,
  input logic load,
  input logic inc,
  output logic fire
);
  logic [TIMEOUT_W-1:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  assign fire = (TIMEOUT != '0) && (cnt == TIMEOUT - 1'b1);
endmodule

// File: rtl/round_seq_ctrl.sv
// round_seq_ctrl: multi-round sequencer driving handshaked sub-block stages with skips and watchdog
// clk, reset (async active-low) plain ports; everything else on bus (round_seq_ctrl_if.master):
// start/abort/num_rounds/lc_mode/skip masks in, one-hot stage_start out, stage_end in,
// round_idx/cur_stage/busy/done/error/err_stage status out.
module round_seq_ctrl
  import round_seq_pkg::*;
#(
  parameter int NUM_STAGES = 8,
  parameter int ROUND_W = 8,
  parameter int TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT = 16'd4096
) (
  input logic clk,
  input logic reset,
  round_seq_ctrl_if.master bus
);
  localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
  state_t state, state_nx;
  logic [ROUND_W-1:0] nr_q, nr_nx, ridx_q, ridx_nx;
  logic [NUM_STAGES-1:0] mask_q, mask_nx, ss_q, ss_nx;
  logic [STG_W-1:0] stg_q, stg_nx, es_q, es_nx;
  logic done_q, done_nx, err_q, err_nx;
  logic adv, wd_load, wd_inc, wd_fire;
  logic [SW-1:0] sidx;
  assign sidx = stg_q[SW-1:0];
  seq_watchdog #(.TIMEOUT_W(TIMEOUT_W), .TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk),
    .reset(reset),
    .load(wd_load),
    .inc(wd_inc),
    .fire(wd_fire)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      nr_q <= '0;
      ridx_q <= '0;
      mask_q <= '0;
      stg_q <= '0;
      ss_q <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      es_q <= '0;
    end else begin
      state <= state_nx;
      nr_q <= nr_nx;
      ridx_q <= ridx_nx;
      mask_q <= mask_nx;
      stg_q <= stg_nx;
      ss_q <= ss_nx;
      done_q <= done_nx;
      err_q <= err_nx;
      es_q <= es_nx;
    end
  always_comb begin
    state_nx = state;
    nr_nx = nr_q;
    ridx_nx = ridx_q;
    mask_nx = mask_q;
    stg_nx = stg_q;
    ss_nx = ss_q;
    done_nx = done_q;
    err_nx = err_q;
    es_nx = es_q;
    adv = 1'b0;
    wd_load = 1'b0;
    wd_inc = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.start) begin
          done_nx = 1'b0;
          err_nx = 1'b0;
        end else if (!done_q && !err_q) begin
          nr_nx = bus.num_rounds;
          ridx_nx = '0;
          state_nx = bus.num_rounds == '0 ? S_DONE : S_INIT;
        end
      end
      // The mask is frozen here so mode/mask changes only take effect at the next round.
      S_INIT: begin
        mask_nx = bus.lc_mode ? bus.skip_lc : bus.skip_nlc;
        stg_nx = '0;
        state_nx = S_SEL;
      end
      S_SEL: begin
        adv = mask_q[sidx];
        if (!mask_q[sidx]) begin
          ss_nx = NUM_STAGES'(1) << sidx;
          wd_load = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        adv = bus.stage_end[sidx];
        wd_inc = !bus.stage_end[sidx];
        if (bus.stage_end[sidx]) ss_nx = '0;
        else if (wd_fire) begin
          ss_nx = '0;
          err_nx = 1'b1;
          es_nx = stg_q;
          state_nx = S_ERR;
        end
      end
      S_DONE: begin
        done_nx = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        if (!bus.start) begin
          err_nx = 1'b0;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (adv) begin
      if (stg_q != STG_W'(NUM_STAGES - 1)) begin
        stg_nx = stg_q + 1'b1;
        state_nx = S_SEL;
      end else if (ridx_q == nr_q - 1'b1) state_nx = S_DONE;
      else begin
        ridx_nx = ridx_q + 1'b1;
        state_nx = S_INIT;
      end
    end
    // Abort overrides every transition, including a stage end that would finish the run.
    if (bus.abort) begin
      state_nx = S_IDLE;
      ss_nx = '0;
      done_nx = done_q & bus.start;
      err_nx = err_q & bus.start;
      es_nx = es_q;
    end
  end
  assign bus.stage_start = ss_q;
  assign bus.round_idx = ridx_q;
  assign bus.cur_stage = stg_q;
  assign bus.busy = state inside {S_INIT, S_SEL, S_WAIT};
  assign bus.done = done_q;
  assign bus.error = err_q;
  assign bus.err_stage = es_q;
endmodule

// File: tb/tb_round_seq_ctrl.sv
// tb_round_seq_ctrl: directed checks of round_seq_ctrl against stub sub-blocks
module tb_round_seq_ctrl;
  import round_seq_pkg::*;
  localparam int NS = 4;
  localparam int RW = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int rise2 = 0;
  int multi = 0;
  logic [NS-1:0] stub_en = '1;
  logic [NS-1:0] stray = '0;
  logic [NS-1:0] prev = '0;
  logic stray_on = 1'b0;
  int stub_cnt [NS];
  int pq[$];
  int rq[$];
  round_seq_ctrl_if #(.NUM_STAGES(NS), .ROUND_W(RW)) bus ();
  round_seq_ctrl #(.NUM_STAGES(NS), .ROUND_W(RW), .TIMEOUT_W(16), .TIMEOUT(16'd16)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  // Stub sub-blocks: end rises 3 cycles after start and drops with start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NS; i++) stub_cnt[i] <= bus.stage_start[i] ? stub_cnt[i] + 1 : 0;
  end
  always_comb begin
    bus.stage_end = stray;
    for (int i = 0; i < NS; i++)
      if (stub_en[i] && bus.stage_start[i] && stub_cnt[i] >= 3) bus.stage_end[i] = 1'b1;
  end
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++)
      if (bus.stage_start[i] && !prev[i]) begin
        pq.push_back(i);
        rq.push_back(int'(bus.round_idx));
        if (i == STG_CH) rise2 = cyc;
      end
    if ($countones(bus.stage_start) > 1) multi++;
    prev = bus.stage_start;
    stray = (stray_on && bus.stage_start[1]) ? 4'b1000 : 4'b0000;
  end
  function automatic logic [31:0] pack(input int q[$]);
    logic [31:0] v = '0;
    foreach (q[k]) v = {v[27:0], 4'(q[k])};
    return v;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic run(input int nr, input logic mode, input logic [NS-1:0] slc,
                     input logic [NS-1:0] snlc, output int cycles);
    @(negedge clk);
    pq.delete();
    rq.delete();
    bus.num_rounds = RW'(nr);
    bus.lc_mode = mode;
    bus.skip_lc = slc;
    bus.skip_nlc = snlc;
    bus.start = 1'b1;
    cycles = 0;
    while (!bus.done && !bus.error && cycles < 10000) begin
      @(negedge clk);
      cycles++;
    end
  endtask
  task automatic stop_run();
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int cy;
    int k;
    logic seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_rounds = '0;
    bus.lc_mode = 1'b0;
    bus.skip_lc = '0;
    bus.skip_nlc = '0;
    @(negedge clk);
    check("rst stage_start", 32'(bus.stage_start), 0);
    check("rst round_idx", 32'(bus.round_idx), 0);
    check("rst cur_stage", 32'(bus.cur_stage), 0);
    check("rst busy", 32'(bus.busy), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst error", 32'(bus.error), 0);
    check("rst err_stage", 32'(bus.err_stage), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    // Two rounds, no skips: 2 + 2*(1 + 4*5) cycles.
    run(2, 1'b0, '0, '0, cy);
    check("t1 cycles", 32'(cy), 44);
    check("t1 order", pack(pq), 32'h01230123);
    check("t1 rounds", pack(rq), 32'h00001111);
    repeat (3) @(negedge clk);
    check("t1 done held", 32'(bus.done), 1);
    check("t1 busy", 32'(bus.busy), 0);
    check("t1 no rerun", 32'(pq.size()), 8);
    bus.start = 1'b0;
    @(negedge clk);
    check("t1 done clr", 32'(bus.done), 0);
    @(negedge clk);
    // Opened round, skip_lc=0101: 2 + 1 + 1+5+1+5.
    run(1, 1'b1, 4'b0101, 4'b1010, cy);
    check("t2 cycles", 32'(cy), 15);
    check("t2 order", pack(pq), 32'h13);
    check("t2 done", 32'(bus.done), 1);
    stop_run();
    // Hidden round, skip_nlc=1000: 2 + 1 + 3*5 + 1.
    run(1, 1'b0, 4'b1111, 4'b1000, cy);
    check("t2b cycles", 32'(cy), 19);
    check("t2b order", pack(pq), 32'h012);
    stop_run();
    // Stage 2 never ends: watchdog fires 16 cycles after its start rises.
    stub_en = 4'b1011;
    run(1, 1'b0, '0, '0, cy);
    check("t3 error", 32'(bus.error), 1);
    check("t3 latency", 32'(cyc - rise2), 16);
    check("t3 err_stage", 32'(bus.err_stage), STG_CH);
    check("t3 starts off", 32'(bus.stage_start), 0);
    check("t3 done", 32'(bus.done), 0);
    check("t3 order", pack(pq), 32'h012);
    repeat (3) @(negedge clk);
    check("t3 error held", 32'(bus.error), 1);
    check("t3 busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    @(negedge clk);
    check("t3 error clr", 32'(bus.error), 0);
    stub_en = '1;
    @(negedge clk);
    // Zero rounds: done two cycles after start, no stage activity.
    run(0, 1'b0, '0, '0, cy);
    check("t4 cycles", 32'(cy), 2);
    check("t4 done", 32'(bus.done), 1);
    check("t4 no starts", 32'(pq.size()), 0);
    stop_run();
    // Abort while waiting on stage 1 of round 1.
    @(negedge clk);
    bus.num_rounds = 8'd2;
    bus.skip_lc = '0;
    bus.skip_nlc = '0;
    bus.start = 1'b1;
    k = 0;
    while (!(bus.round_idx == 8'd1 && bus.cur_stage == 5'd1 && bus.stage_start[1]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5 reach", 32'(k < 200), 1);
    bus.abort = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    check("t5 starts off", 32'(bus.stage_start), 0);
    check("t5 busy", 32'(bus.busy), 0);
    check("t5 done", 32'(bus.done), 0);
    @(negedge clk);
    // Abort in the same cycle as the final stage end: no done.
    bus.num_rounds = 8'd1;
    bus.start = 1'b1;
    k = 0;
    while (!(bus.cur_stage == 5'd3 && bus.stage_end[3]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t5b reach", 32'(k < 200), 1);
    bus.abort = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.abort = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      seen |= bus.done | bus.busy;
      @(negedge clk);
    end
    check("t5b abort wins", 32'(seen), 0);
    run(1, 1'b0, '0, '0, cy);
    check("t5c cycles", 32'(cy), 23);
    check("t5c order", pack(pq), 32'h0123);
    check("t5c rounds", pack(rq), 32'h0000);
    stop_run();
    // Stray stage_end[3] while waiting on stage 1 must be ignored.
    stray_on = 1'b1;
    run(1, 1'b0, '0, '0, cy);
    check("t6 cycles", 32'(cy), 23);
    check("t6 order", pack(pq), 32'h0123);
    stray_on = 1'b0;
    stop_run();
    // Largest round count runs without wrap: 2 + 255*21.
    run(255, 1'b0, '0, '0, cy);
    check("t7 cycles", 32'(cy), 5357);
    check("t7 pulses", 32'(pq.size()), 1020);
    check("t7 last round", 32'(rq[$]), 254);
    check("t7 done", 32'(bus.done), 1);
    stop_run();
    // Asynchronous reset mid-run.
    bus.num_rounds = 8'd2;
    bus.start = 1'b1;
    k = 0;
    while (!(bus.round_idx == 8'd1 && bus.stage_start[2]) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("t8 reach", 32'(k < 200), 1);
    #2 reset = 1'b0;
    #1;
    check("t8 starts off", 32'(bus.stage_start), 0);
    check("t8 round_idx", 32'(bus.round_idx), 0);
    check("t8 cur_stage", 32'(bus.cur_stage), 0);
    check("t8 busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("onehot starts", 32'(multi), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
